// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 line decoder: widths and the decode function.
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    // One-hot decode of a 3-bit select; an unknown select yields an all-X vector
    // so that undefined inputs are visible downstream in simulation.
    function automatic logic [OUT_W-1:0] onehot_decode(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] vec;
        case (sel)
            3'd0:    vec = 8'b0000_0001;
            3'd1:    vec = 8'b0000_0010;
            3'd2:    vec = 8'b0000_0100;
            3'd3:    vec = 8'b0000_1000;
            3'd4:    vec = 8'b0001_0000;
            3'd5:    vec = 8'b0010_0000;
            3'd6:    vec = 8'b0100_0000;
            3'd7:    vec = 8'b1000_0000;
            default: vec = 'x;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/decoder3_8_core.sv
// Purely combinational 3-bit to 8-bit one-hot decoder core.
module decoder3_8_core
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    // Decode the select into exactly one asserted line.
    always_comb begin
        onehot = onehot_decode(sel);
    end

endmodule

// File: rtl/decoder3_8.sv
// 3-to-8 line decoder with scalar ports and an optional registered output path.
module decoder3_8
    import decoder_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    output logic D7,
    output logic D6,
    output logic D5,
    output logic D4,
    output logic D3,
    output logic D2,
    output logic D1,
    output logic D0
);

    logic [SEL_W-1:0] sel_p0;
    logic [OUT_W-1:0] dec_p0;
    logic [OUT_W-1:0] dec_out;

    assign sel_p0 = {A2, A1, A0};

    decoder3_8_core u_core (
        .sel    (sel_p0),
        .onehot (dec_p0)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [OUT_W-1:0] dec_p1;

            // ---- stage p0 -> p1: register the decode; reset clears all lines at once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dec_p1 <= '0;
                end else begin
                    dec_p1 <= dec_p0;
                end
            end

            assign dec_out = dec_p1;
        end else begin : g_comb
            // clk and rst_n have no function on the combinational path.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};
            assign dec_out = dec_p0;
        end
    endgenerate

    assign {D7, D6, D5, D4, D3, D2, D1, D0} = dec_out;

endmodule

// File: tb/tb_decoder3_8.sv
// Directed bench: one combinational and one registered decoder share the select inputs.
module tb_decoder3_8;

    logic clk;
    logic rst_n;
    logic A2, A1, A0;
    logic c7, c6, c5, c4, c3, c2, c1, c0;
    logic r7, r6, r5, r4, r3, r2, r1, r0;
    logic [7:0] dc, dr;

    int checks   = 0;
    int failures = 0;
    logic four_state;
    logic [7:0] exp_tab [8];

    decoder3_8 #(.REG_OUT(1'b0)) u_comb (
        .clk(1'bz), .rst_n(1'bz),
        .A2(A2), .A1(A1), .A0(A0),
        .D7(c7), .D6(c6), .D5(c5), .D4(c4), .D3(c3), .D2(c2), .D1(c1), .D0(c0)
    );

    decoder3_8 #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .A2(A2), .A1(A1), .A0(A0),
        .D7(r7), .D6(r6), .D5(r5), .D4(r4), .D3(r3), .D2(r2), .D1(r1), .D0(r0)
    );

    assign dc = {c7, c6, c5, c4, c3, c2, c1, c0};
    assign dr = {r7, r6, r5, r4, r3, r2, r1, r0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_pop(input string tag, input logic [7:0] obs);
        int pc;
        pc = $countones(obs);
        checks++;
        assert (pc === 1) else begin
            failures++;
            $error("FAIL %s popcount observed=%0d expected=1 (D=%b)", tag, pc, obs);
        end
    endtask

    task automatic set_sel(input logic [2:0] s);
        {A2, A1, A0} = s;
    endtask

    initial begin
        exp_tab[0] = 8'b0000_0001; exp_tab[1] = 8'b0000_0010;
        exp_tab[2] = 8'b0000_0100; exp_tab[3] = 8'b0000_1000;
        exp_tab[4] = 8'b0001_0000; exp_tab[5] = 8'b0010_0000;
        exp_tab[6] = 8'b0100_0000; exp_tab[7] = 8'b1000_0000;
        four_state = 1'bx;

        // Reset held with sel=6, before any clock edge
        rst_n = 1'b0;
        set_sel(3'd6);
        #1;
        check("reg_reset_pre_edge", dr, 8'h00);
        check("comb_sel6", dc, 8'b0100_0000);

        // Combinational sweep; registered copy stays cleared throughout reset
        for (int s = 0; s < 8; s++) begin
            set_sel(s[2:0]);
            #1;
            check($sformatf("comb_sweep_sel%0d", s), dc, exp_tab[s]);
            check($sformatf("reg_in_reset_sel%0d", s), dr, 8'h00);
            #19;
        end
        set_sel(3'd5);
        #1;
        check("comb_sel5_literal", dc, 8'b0010_0000);
        set_sel(3'b011);
        #1;
        check("comb_sel3_undriven_clk", dc, 8'b0000_1000);

        // Release reset with sel=6: zero until the first edge, then D6
        @(negedge clk);
        set_sel(3'd6);
        rst_n = 1'b1;
        #1;
        check("reg_after_release_no_edge", dr, 8'h00);
        @(posedge clk); #1;
        check("reg_first_edge_sel6", dr, 8'b0100_0000);
        check_pop("reg_pop_first", dr);

        // Latency: mid-cycle change from 2 to 7 held off until next edge
        @(negedge clk);
        set_sel(3'd2);
        @(posedge clk); #1;
        check("reg_sel2", dr, 8'b0000_0100);
        #2;
        set_sel(3'd7);
        #1;
        check("reg_sel2_hold_midcycle", dr, 8'b0000_0100);
        check("comb_sel7_immediate", dc, 8'b1000_0000);
        @(posedge clk); #1;
        check("reg_sel7", dr, 8'b1000_0000);
        check_pop("reg_pop_sel7", dr);

        // Back-to-back select changes on consecutive edges
        @(negedge clk); set_sel(3'd0);
        @(posedge clk); #1; check("b2b_sel0", dr, 8'b0000_0001); check_pop("b2b_pop0", dr);
        @(negedge clk); set_sel(3'd5);
        @(posedge clk); #1; check("b2b_sel5", dr, 8'b0010_0000); check_pop("b2b_pop5", dr);
        @(negedge clk); set_sel(3'd3);
        @(posedge clk); #1; check("b2b_sel3", dr, 8'b0000_1000); check_pop("b2b_pop3", dr);
        @(negedge clk); set_sel(3'd1);
        @(posedge clk); #1; check("b2b_sel1", dr, 8'b0000_0010); check_pop("b2b_pop1", dr);

        // Mid-operation reset clears immediately between edges
        @(negedge clk); set_sel(3'd4);
        @(posedge clk); #1;
        check("reg_sel4", dr, 8'b0001_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("reg_async_clear", dr, 8'h00);
        @(posedge clk); #1;
        check("reg_held_in_reset", dr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reg_release2_no_edge", dr, 8'h00);
        @(posedge clk); #1;
        check("reg_release2_sel4", dr, 8'b0001_0000);

        // Unknown select propagates as X where the simulator models it
        @(negedge clk);
        set_sel(3'd2);
        A1 = 1'bx;
        #1;
        if (four_state === 1'bx) begin
            check("comb_x_input", dc, 8'bxxxx_xxxx);
            @(posedge clk); #1;
            check("reg_x_input", dr, 8'bxxxx_xxxx);
            @(negedge clk);
        end
        A1 = 1'b0;
        #1;
        check("comb_x_restore", dc, 8'b0000_0001);
        @(posedge clk); #1;
        check("reg_x_restore", dr, 8'b0000_0001);
        check_pop("reg_pop_restore", dr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
